// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Package  : mem_arb_pkg
// Purpose  : FSM state encoding, op codes and port ids shared by mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_A    = 2'b01;
    localparam logic [1:0] OP_B    = 2'b10;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    function automatic logic op_active(input logic [1:0] op);
        return (op == OP_A) || (op == OP_B);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates an instruction-fetch port and a data port onto a single
//            multi-cycle memory controller, with fetch starvation protection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_data,
    output logic        if_ack,

    input  logic [1:0]  d_memRead,
    input  logic [1:0]  d_memWrite,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,

    output logic        stall,

    output logic [15:0] mc_address,
    output logic [15:0] mc_dataIn,
    output logic [1:0]  mc_memRead,
    output logic [1:0]  mc_memWrite,
    input  logic [15:0] mc_dataOut
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] CNT_LOAD   = CW'(ACCESS_CYCLES - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          port_q,   port_d;
    logic [15:0]   addr_q,   addr_d;
    logic [15:0]   wdata_q,  wdata_d;
    logic [1:0]    rd_q,     rd_d;
    logic [1:0]    wr_q,     wr_d;
    logic [15:0]   if_data_q, if_data_d;
    logic [15:0]   d_rdata_q, d_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q,  d_ack_d;

    logic          d_valid;
    logic          grant_if;

    // Data port normally wins; fetch wins only once the data streak has saturated.
    function automatic logic grant_fetch(input logic          req_if,
                                         input logic          req_d,
                                         input logic [SW-1:0] streak);
        return req_if && (!req_d || (streak == STREAK_MAX));
    endfunction

    assign d_valid = (op_active(d_memRead)  && (d_memWrite == OP_NONE)) ||
                     (op_active(d_memWrite) && (d_memRead  == OP_NONE));

    assign grant_if = grant_fetch(if_req, d_valid, streak_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        streak_d  = streak_q;
        port_d    = port_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        if_data_d = if_data_q;
        d_rdata_d = d_rdata_q;
        if_ack_d  = 1'b0;
        d_ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                    if (grant_if) begin
                        port_d   = PORT_IF;
                        addr_d   = if_addr;
                        rd_d     = OP_A;
                        wr_d     = OP_NONE;
                        streak_d = '0;
                    end else begin
                        port_d  = PORT_D;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        rd_d    = d_memRead;
                        wr_d    = d_memWrite;
                        if (!if_req) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end
                end
            end

            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                if (port_q == PORT_IF) begin
                    if_data_d = mc_dataOut;
                    if_ack_d  = 1'b1;
                end else begin
                    // A data write completes without disturbing the last read word.
                    if (rd_q != OP_NONE) begin
                        d_rdata_d = mc_dataOut;
                    end
                    d_ack_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            streak_q  <= '0;
            port_q    <= PORT_IF;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= OP_NONE;
            wr_q      <= OP_NONE;
            if_data_q <= '0;
            d_rdata_q <= '0;
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            if_data_q <= if_data_d;
            d_rdata_q <= d_rdata_d;
            if_ack_q  <= if_ack_d;
            d_ack_q   <= d_ack_d;
        end
    end

    assign mc_address  = addr_q;
    assign mc_dataIn   = wdata_q;
    assign mc_memRead  = (state_q == ST_BUSY) ? rd_q : OP_NONE;
    assign mc_memWrite = (state_q == ST_BUSY) ? wr_q : OP_NONE;

    assign if_data = if_data_q;
    assign if_ack  = if_ack_q;
    assign d_rdata = d_rdata_q;
    assign d_ack   = d_ack_q;

    assign stall = (if_req & ~if_ack_q) | (d_valid & ~d_ack_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter (ACCESS_CYCLES=2 and =1 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int          ACC  = 2;
    localparam logic [15:0] KEY  = 16'hABDD;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;

    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_data;
    logic        if_ack;
    logic [1:0]  d_memRead;
    logic [1:0]  d_memWrite;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        stall;
    logic [15:0] mc_address;
    logic [15:0] mc_dataIn;
    logic [1:0]  mc_memRead;
    logic [1:0]  mc_memWrite;
    logic [15:0] mc_dataOut;

    logic        b_if_req;
    logic [15:0] b_if_addr;
    logic [15:0] b_if_data;
    logic        b_if_ack;
    logic [15:0] b_d_rdata;
    logic        b_d_ack;
    logic        b_stall;
    logic [15:0] b_mc_address;
    logic [15:0] b_mc_dataIn;
    logic [1:0]  b_mc_memRead;
    logic [1:0]  b_mc_memWrite;
    logic [15:0] b_mc_dataOut;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [15:0] exp_rdata;

    // Memory model: read data is a fixed function of the address.
    assign mc_dataOut   = mc_address ^ KEY;
    assign b_mc_dataOut = b_mc_address ^ KEY;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ACCESS_CYCLES(ACC), .STARVE_LIMIT(4)) u_dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack),
        .d_memRead(d_memRead), .d_memWrite(d_memWrite), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .stall(stall),
        .mc_address(mc_address), .mc_dataIn(mc_dataIn), .mc_memRead(mc_memRead),
        .mc_memWrite(mc_memWrite), .mc_dataOut(mc_dataOut)
    );

    mem_arbiter #(.ACCESS_CYCLES(1), .STARVE_LIMIT(4)) u_dut1 (
        .CLK(CLK), .RST(RST),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_data(b_if_data), .if_ack(b_if_ack),
        .d_memRead(OP_NONE), .d_memWrite(OP_NONE), .d_addr(16'h0000),
        .d_wdata(16'h0000), .d_rdata(b_d_rdata), .d_ack(b_d_ack), .stall(b_stall),
        .mc_address(b_mc_address), .mc_dataIn(b_mc_dataIn), .mc_memRead(b_mc_memRead),
        .mc_memWrite(b_mc_memWrite), .mc_dataOut(b_mc_dataOut)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST === 1'b1 && (if_ack || d_ack)) begin
            if (if_ack && d_ack) check("dual_ack", 1, 0);
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", {31'd0, d_ack}, {31'd0, e.port});
                check("ack_data", {16'd0, (if_ack ? if_data : d_rdata)}, {16'd0, e.data});
            end
        end
    end

    // Drives one isolated access from a negedge and follows it to its ack.
    task automatic do_access(input bit is_fetch, input logic [1:0] rd, input logic [1:0] wr,
                             input logic [15:0] addr, input logic [15:0] wdata);
        int lat;
        bit got;
        lat = 0;
        got = 0;
        if (is_fetch) begin
            if_req  = 1'b1;
            if_addr = addr;
            sb.push_back('{PORT_IF, addr ^ KEY});
        end else begin
            d_memRead  = rd;
            d_memWrite = wr;
            d_addr     = addr;
            d_wdata    = wdata;
            if (rd != OP_NONE) exp_rdata = addr ^ KEY;
            sb.push_back('{PORT_D, exp_rdata});
        end
        while (!got && lat < 20) begin
            @(negedge CLK);
            lat++;
            if (lat == 1) begin
                check("busy_addr", {16'd0, mc_address}, {16'd0, addr});
                check("busy_rd",   {30'd0, mc_memRead},  {30'd0, (is_fetch ? OP_A : rd)});
                check("busy_wr",   {30'd0, mc_memWrite}, {30'd0, (is_fetch ? OP_NONE : wr)});
                check("busy_stall", {31'd0, stall}, 1);
                if (!is_fetch && wr != OP_NONE)
                    check("busy_wdata", {16'd0, mc_dataIn}, {16'd0, wdata});
            end
            if (lat == ACC + 1) begin
                check("resp_ops", {28'd0, mc_memRead, mc_memWrite}, 0);
            end
            if (if_ack || d_ack) begin
                got = 1;
                check("ack_stall", {31'd0, stall}, 0);
            end
        end
        check("latency", lat, ACC + 2);
        if (is_fetch) if_req = 1'b0;
        else begin
            d_memRead  = OP_NONE;
            d_memWrite = OP_NONE;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int acks;
        int cyc;
        int lat;
        logic [15:0] addrs [3];

        RST        = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        d_memRead  = OP_NONE;
        d_memWrite = OP_NONE;
        d_addr     = '0;
        d_wdata    = '0;
        b_if_req   = 1'b0;
        b_if_addr  = '0;
        exp_rdata  = '0;

        repeat (3) @(negedge CLK);
        check("rst_acks",  {30'd0, if_ack, d_ack}, 0);
        check("rst_ops",   {28'd0, mc_memRead, mc_memWrite}, 0);
        check("rst_addr",  {mc_address, mc_dataIn}, 0);
        check("rst_rdata", {if_data, d_rdata}, 0);
        check("rst_stall", {31'd0, stall}, 0);
        RST = 1'b1;

        // Both ports idle: nothing moves.
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            bad += int'(stall | if_ack | d_ack | (mc_memRead != OP_NONE) | (mc_memWrite != OP_NONE));
        end
        check("idle_quiet", bad, 0);

        do_access(1'b1, OP_NONE, OP_NONE, 16'h0010, 16'h0000);   // if_data = 0xABCD
        do_access(1'b0, OP_B, OP_NONE, 16'h2222, 16'h0000);
        do_access(1'b0, OP_NONE, OP_A, 16'h4000, 16'h1234);
        check("write_keeps_rdata", {16'd0, d_rdata}, {16'd0, 16'h2222 ^ KEY});
        do_access(1'b0, OP_A, OP_NONE, 16'h3030, 16'h0000);

        // Illegal op combinations are never granted.
        d_memRead  = OP_A;
        d_memWrite = OP_A;
        bad = 0;
        repeat (6) begin
            @(negedge CLK);
            bad += int'(stall | d_ack | (mc_memRead != OP_NONE) | (mc_memWrite != OP_NONE));
        end
        check("illegal_01_01", bad, 0);
        d_memRead  = 2'b11;
        d_memWrite = OP_NONE;
        bad = 0;
        repeat (6) begin
            @(negedge CLK);
            bad += int'(stall | d_ack | (mc_memRead != OP_NONE) | (mc_memWrite != OP_NONE));
        end
        check("illegal_11_00", bad, 0);
        do_access(1'b1, OP_NONE, OP_NONE, 16'h0300, 16'h0000);
        d_memRead = OP_NONE;

        // A request dropped after the grant still completes with its original address.
        if_req  = 1'b1;
        if_addr = 16'h0C0C;
        sb.push_back('{PORT_IF, 16'h0C0C ^ KEY});
        @(negedge CLK);
        if_req  = 1'b0;
        if_addr = 16'hFFFF;
        lat = 1;
        while (!if_ack && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("dropped_latency", lat, ACC + 2);

        // Both ports held: four data grants, then one fetch, repeating.
        if_req     = 1'b1;
        if_addr    = 16'h0600;
        d_memRead  = OP_B;
        d_addr     = 16'h0700;
        exp_rdata  = 16'h0700 ^ KEY;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) sb.push_back('{PORT_IF, 16'h0600 ^ KEY});
            else            sb.push_back('{PORT_D, exp_rdata});
        end
        acks = 0;
        cyc  = 0;
        while (acks < 10 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (if_ack || d_ack) acks++;
        end
        check("simul_acks", acks, 10);
        check("simul_cycles", cyc, 10 * (ACC + 2));
        if_req    = 1'b0;
        d_memRead = OP_NONE;
        @(negedge CLK);

        // Reset in the first BUSY cycle aborts the access without an ack.
        if_req  = 1'b1;
        if_addr = 16'h0500;
        @(negedge CLK);
        check("rstbusy_op", {30'd0, mc_memRead}, {30'd0, OP_A});
        RST = 1'b0;
        @(negedge CLK);
        check("rstbusy_ops",  {28'd0, mc_memRead, mc_memWrite}, 0);
        check("rstbusy_acks", {30'd0, if_ack, d_ack}, 0);
        check("rstbusy_data", {if_data, mc_address}, 0);
        RST = 1'b1;
        sb.push_back('{PORT_IF, 16'h0500 ^ KEY});
        lat = 0;
        while (!if_ack && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("reissue_latency", lat, ACC + 2);
        if_req = 1'b0;
        repeat (3) @(negedge CLK);
        check("sb_empty", sb.size(), 0);

        // Single-cycle build: back-to-back fetches ack every three cycles.
        addrs[0] = 16'h0800;
        addrs[1] = 16'h0900;
        addrs[2] = 16'h0A00;
        b_if_req  = 1'b1;
        b_if_addr = addrs[0];
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(negedge CLK);
                cyc++;
            end while (!b_if_ack && cyc < 20);
            check("b_ack_gap", cyc, 3);
            check("b_if_data", {16'd0, b_if_data}, {16'd0, addrs[k] ^ KEY});
            if (k < 2) b_if_addr = addrs[k + 1];
        end
        b_if_req = 1'b0;
        repeat (3) @(negedge CLK);
        check("b_idle", {29'd0, b_if_ack, b_stall, b_d_ack}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
